// File: rtl/wbu_pkg.sv
// Shared constants and length-code helpers for the bus-output codeword path.
package wbu_pkg;

  localparam int unsigned CW   = 36;
  localparam int unsigned CHW  = 6;
  localparam int unsigned REMW = 3;

  localparam logic [1:0] LEN1 = 2'b11;
  localparam logic [1:0] LEN2 = 2'b10;
  localparam logic [1:0] LEN3 = 2'b01;
  localparam logic [1:0] LEN6 = 2'b00;

  // Number of characters following the first one, for a 2-bit length code.
  function automatic logic [REMW-1:0] len_rem(input logic [1:0] code);
    logic [REMW-1:0] r;
    case (code)
      LEN1:    r = REMW'(0);
      LEN2:    r = REMW'(1);
      LEN3:    r = REMW'(2);
      default: r = REMW'(5);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wbu_deword_tx.sv
// Serializes 36-bit codewords popped from the output FIFO into 1/2/3/6
// six-bit characters, MSB first, one per clock with no bubble between words.
module wbu_deword_tx
  import wbu_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_stb,
  input  logic [CW-1:0]   i_word,
  output logic            o_rd,
  output logic            o_stb,
  output logic [CHW-1:0]  o_char,
  input  logic            i_busy,
  output logic            o_active
);

  logic            stb_q,  stb_d;
  logic [CHW-1:0]  char_q, char_d;
  logic [CW-1:0]   sreg_q, sreg_d;
  logic [REMW-1:0] rem_q,  rem_d;
  logic            accept_c;

  assign accept_c = stb_q && !i_busy;

  // Pop only when idle, or when the last character of the current word leaves.
  assign o_rd = i_stb && (!stb_q || (accept_c && (rem_q == REMW'(0))));

  always_comb begin
    stb_d  = stb_q;
    char_d = char_q;
    sreg_d = sreg_q;
    rem_d  = rem_q;
    if (o_rd) begin
      stb_d  = 1'b1;
      char_d = i_word[CW-1 -: CHW];
      sreg_d = i_word << CHW;
      rem_d  = len_rem(i_word[CW-1 -: 2]);
    end else if (accept_c) begin
      if (rem_q != REMW'(0)) begin
        char_d = sreg_q[CW-1 -: CHW];
        sreg_d = sreg_q << CHW;
        rem_d  = rem_q - REMW'(1);
      end else begin
        stb_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stb_q  <= 1'b0;
      char_q <= '0;
      sreg_q <= '0;
      rem_q  <= '0;
    end else begin
      stb_q  <= stb_d;
      char_q <= char_d;
      sreg_q <= sreg_d;
      rem_q  <= rem_d;
    end
  end

  assign o_stb    = stb_q;
  assign o_char   = char_q;
  assign o_active = stb_q;

endmodule

// File: tb/tb_wbu_deword_tx.sv
// Directed bench for wbu_deword_tx with a one-cycle-latency FIFO model.
module tb_wbu_deword_tx;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_stb;
  logic [35:0] i_word;
  logic        o_rd;
  logic        o_stb;
  logic [5:0]  o_char;
  logic        i_busy = 1'b0;
  logic        o_active;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int empty_reads = 0;

  logic [35:0] fifo_mem [0:15];
  int wr_cnt = 0;
  int rd_ptr = 0;

  logic [5:0] acc_ch[$];
  int         acc_cyc[$];
  int         rd_cyc[$];

  logic [5:0] exp_w6 [0:5] = '{6'h00, 6'h12, 6'h0D, 6'h05, 6'h19, 6'h38};
  logic [5:0] exp_st [0:5] = '{6'h30, 6'h21, 6'h00, 6'h10, 6'h00, 6'h00};

  wbu_deword_tx dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_stb    (i_stb),
    .i_word   (i_word),
    .o_rd     (o_rd),
    .o_stb    (o_stb),
    .o_char   (o_char),
    .i_busy   (i_busy),
    .o_active (o_active)
  );

  always #5 i_clk = ~i_clk;

  assign i_stb  = (rd_ptr < wr_cnt);
  assign i_word = fifo_mem[rd_ptr[3:0]];

  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (o_rd) rd_ptr <= rd_ptr + 1;
  end

  // Log accepted characters and pops at mid-cycle, when inputs are settled.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_stb && !i_busy) begin
        acc_ch.push_back(o_char);
        acc_cyc.push_back(cyc);
      end
      if (o_rd) rd_cyc.push_back(cyc);
      if (o_rd && !i_stb) empty_reads++;
    end
  end

  task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [35:0] w);
    fifo_mem[wr_cnt[3:0]] = w;
    wr_cnt = wr_cnt + 1;
  endtask

  task automatic sync();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_idle(input int max_cyc);
    logic done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge i_clk);
      if (!o_stb && !i_stb) done = 1'b1;
    end
    check_eq("idle_timeout", 36'(done), 36'd1);
  endtask

  initial begin
    int b, r;

    // Reset, then idle with empty FIFO.
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      check_eq("idle_stb", 36'(o_stb), 36'd0);
      check_eq("idle_rd", 36'(o_rd), 36'd0);
      check_eq("idle_char", 36'(o_char), 36'd0);
      check_eq("idle_active", 36'(o_active), 36'd0);
    end

    // Single 6-char word.
    sync();
    b = acc_ch.size(); r = rd_cyc.size();
    push(36'h0_1234_5678);
    wait_idle(40);
    check_eq("w6_nrd", 36'(rd_cyc.size() - r), 36'd1);
    check_eq("w6_nchar", 36'(acc_ch.size() - b), 36'd6);
    if (acc_ch.size() - b == 6 && rd_cyc.size() - r == 1) begin
      check_eq("w6_lat", 36'(acc_cyc[b] - rd_cyc[r]), 36'd1);
      for (int i = 0; i < 6; i++) begin
        check_eq($sformatf("w6_char%0d", i), 36'(acc_ch[b+i]), 36'(exp_w6[i]));
        if (i > 0) check_eq($sformatf("w6_gap%0d", i), 36'(acc_cyc[b+i] - acc_cyc[b+i-1]), 36'd1);
      end
    end

    // Stream of 1-, 2-, 3-char words, no bubbles.
    sync();
    b = acc_ch.size(); r = rd_cyc.size();
    push(36'hC_0000_0000);
    push(36'h8_4000_0000);
    push(36'h4_0000_0000);
    wait_idle(40);
    check_eq("st_nrd", 36'(rd_cyc.size() - r), 36'd3);
    check_eq("st_nchar", 36'(acc_ch.size() - b), 36'd6);
    if (acc_ch.size() - b == 6 && rd_cyc.size() - r == 3) begin
      check_eq("st_rd1", 36'(rd_cyc[r+1] - rd_cyc[r]), 36'd1);
      check_eq("st_rd2", 36'(rd_cyc[r+2] - rd_cyc[r]), 36'd3);
      check_eq("st_lat", 36'(acc_cyc[b] - rd_cyc[r]), 36'd1);
      for (int i = 0; i < 6; i++) begin
        check_eq($sformatf("st_char%0d", i), 36'(acc_ch[b+i]), 36'(exp_st[i]));
        if (i > 0) check_eq($sformatf("st_gap%0d", i), 36'(acc_cyc[b+i] - acc_cyc[b+i-1]), 36'd1);
      end
    end

    // Busy stall on the 2nd character of a 6-char word.
    sync();
    b = acc_ch.size();
    push(36'h0_1234_5678);
    @(posedge i_clk);
    @(posedge i_clk);
    #1 i_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      check_eq("bz_char_hold", 36'(o_char), 36'h12);
      check_eq("bz_stb_hold", 36'(o_stb), 36'd1);
    end
    @(posedge i_clk);
    #1 i_busy = 1'b0;
    wait_idle(40);
    check_eq("bz_nchar", 36'(acc_ch.size() - b), 36'd6);
    if (acc_ch.size() - b == 6)
      for (int i = 0; i < 6; i++)
        check_eq($sformatf("bz_char%0d", i), 36'(acc_ch[b+i]), 36'(exp_w6[i]));

    // Busy on the last character with the next word waiting.
    sync();
    b = acc_ch.size();
    push(36'h8_4000_0000);
    push(36'hC_0000_0000);
    @(posedge i_clk);
    @(posedge i_clk);
    #1 i_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check_eq("lb_rd_held", 36'(o_rd), 36'd0);
      check_eq("lb_char", 36'(o_char), 36'h00);
      check_eq("lb_stb_in", 36'(i_stb), 36'd1);
    end
    @(posedge i_clk);
    #1 i_busy = 1'b0;
    @(negedge i_clk);
    check_eq("lb_rd_go", 36'(o_rd), 36'd1);
    @(posedge i_clk);
    #1;
    check_eq("lb_next_char", 36'(o_char), 36'h30);
    check_eq("lb_next_stb", 36'(o_stb), 36'd1);
    wait_idle(40);
    check_eq("lb_nchar", 36'(acc_ch.size() - b), 36'd3);
    check_eq("empty_reads", 36'(empty_reads), 36'd0);

    // Asynchronous reset mid-word, then a fresh 1-char word.
    sync();
    push(36'h0_1234_5678);
    @(posedge i_clk);
    @(posedge i_clk);
    @(posedge i_clk);
    #2;
    check_eq("rs_char3", 36'(o_char), 36'h0D);
    i_reset = 1'b1;
    #1;
    check_eq("rs_stb", 36'(o_stb), 36'd0);
    check_eq("rs_active", 36'(o_active), 36'd0);
    check_eq("rs_char", 36'(o_char), 36'd0);
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;
    b = acc_ch.size(); r = rd_cyc.size();
    push(36'hF_C000_0000);
    wait_idle(40);
    check_eq("rs_nrd", 36'(rd_cyc.size() - r), 36'd1);
    check_eq("rs_nchar", 36'(acc_ch.size() - b), 36'd1);
    if (acc_ch.size() - b == 1) check_eq("rs_char_new", 36'(acc_ch[b]), 36'h3F);
    check_eq("rs_end_stb", 36'(o_stb), 36'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
